// File: rtl/uart_word_io_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_word_io_pkg : shared FSM encodings and constants for uart_word_io      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_word_io_pkg;

  localparam int UART_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_COLLECT = 2'd1,
    RD_DONE    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_word_io_if.sv
// +----------------------------------------------------------------------------+
// | uart_word_io_if : exec-stage word write/read handshake bundle              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_word_io_if;
  logic        uart_wenable;
  logic [31:0] uart_wd;
  logic        uart_wdone;
  logic        uart_renable;
  logic        uart_rdone;
  logic [31:0] uart_rd;

  modport master (
    output uart_wenable, uart_wd, uart_renable,
    input  uart_wdone, uart_rdone, uart_rd
  );

  modport slave (
    input  uart_wenable, uart_wd, uart_renable,
    output uart_wdone, uart_rdone, uart_rd
  );
endinterface

`default_nettype wire

// File: rtl/uart_word_io_rx_fifo.sv
// +----------------------------------------------------------------------------+
// | uart_rx_fifo : synchronous byte FIFO with registered count                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_PTR_W:0]   count_q;
  logic               w_push, w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (c_PTR_W+1)'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (c_PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (c_PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_word_io.sv
// +----------------------------------------------------------------------------+
// | uart_word_io : 32-bit word UART responder (4x 8N1 bytes, MSB byte first)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_word_io
  import uart_word_io_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic          clk,
  input  logic          rstn,
  uart_word_io_if.slave bus,
  output logic          txd,
  input  logic          rxd,
  output logic          rx_overflow
);

  localparam int              c_CNT_W     = $clog2(CLK_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(CLK_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF     = c_CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [1:0]         c_LAST_BYTE = 2'(UART_BYTES_PER_WORD - 1);

  // ---------------- TX serializer ----------------
  tx_state_t          tx_state_q, tx_state_d;
  logic [c_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]         tx_bit_q, tx_bit_d;
  logic [1:0]         tx_byte_q, tx_byte_d;
  logic [31:0]        tx_word_q, tx_word_d;
  logic               txd_q, txd_d;
  logic               w_tx_tick;
  logic [7:0]         w_tx_cur;
  logic [2:0]         w_tx_nxt;

  assign w_tx_tick      = (tx_cnt_q == c_BIT_LAST);
  assign w_tx_cur       = tx_word_q[31:24];
  assign w_tx_nxt       = tx_bit_q + 3'd1;
  assign txd            = txd_q;
  assign bus.uart_wdone = (tx_state_q == TX_DONE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_word_d  = tx_word_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (bus.uart_wenable) begin
          tx_word_d  = bus.uart_wd;
          tx_byte_d  = 2'd0;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (w_tx_tick) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          txd_d      = w_tx_cur[0];
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q + c_CNT_ONE;
      end
      TX_DATA: begin
        if (w_tx_tick) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = w_tx_nxt;
            txd_d    = w_tx_cur[w_tx_nxt];
          end
        end else tx_cnt_d = tx_cnt_q + c_CNT_ONE;
      end
      TX_STOP: begin
        if (w_tx_tick) begin
          tx_cnt_d = '0;
          if (tx_byte_q == c_LAST_BYTE) begin
            tx_state_d = TX_DONE;
          end else begin
            tx_byte_d  = tx_byte_q + 2'd1;
            tx_word_d  = {tx_word_q[23:0], 8'h00};
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end
        end else tx_cnt_d = tx_cnt_q + c_CNT_ONE;
      end
      TX_DONE:  tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_word_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_word_q  <= tx_word_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------- RX deserializer ----------------
  rx_state_t          rx_state_q, rx_state_d;
  logic [c_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [7:0]         rx_sh_q, rx_sh_d;
  logic               rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic               push_q, push_d;
  logic [7:0]         push_data_q, push_data_d;
  logic               overflow_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid-start recheck rejects glitches and aligns sampling to bit centres.
        if (rx_cnt_q == c_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + c_CNT_ONE;
      end
      RX_DATA: begin
        if (rx_cnt_q == c_BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxd_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + c_CNT_ONE;
      end
      RX_STOP: begin
        if (rx_cnt_q == c_BIT_LAST) begin
          rx_state_d  = RX_IDLE;
          push_d      = rxd_s2_q;
          push_data_d = rx_sh_q;
        end else rx_cnt_d = rx_cnt_q + c_CNT_ONE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      rxd_s1_q    <= rxd;
      rxd_s2_q    <= rxd_s1_q;
      rxd_prev_q  <= rxd_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // ---------------- RX byte buffer ----------------
  logic       w_fifo_pop, w_fifo_empty, w_fifo_full;
  logic [7:0] w_fifo_data;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .pop_i   (w_fifo_pop),
    .data_o  (w_fifo_data),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      overflow_q <= 1'b0;
    else if (push_q && w_fifo_full) overflow_q <= 1'b1;
  end

  assign rx_overflow = overflow_q;

  // ---------------- Read FSM ----------------
  rd_state_t   rd_state_q, rd_state_d;
  logic [1:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0] rd_acc_q, rd_acc_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic        rdone_q, rdone_d;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_acc_d   = rd_acc_q;
    rd_word_d  = rd_word_q;
    rdone_d    = 1'b0;
    w_fifo_pop = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        // The cycle showing rdone still carries the finished request's enable.
        if (bus.uart_renable && !rdone_q) begin
          rd_cnt_d   = 2'd0;
          rd_state_d = RD_COLLECT;
        end
      end
      RD_COLLECT: begin
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          rd_acc_d   = {rd_acc_q[23:0], w_fifo_data};
          rd_cnt_d   = rd_cnt_q + 2'd1;
          if (rd_cnt_q == c_LAST_BYTE) rd_state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        rdone_d    = 1'b1;
        rd_word_d  = rd_acc_q;
        rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= '0;
      rd_acc_q   <= '0;
      rd_word_q  <= '0;
      rdone_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_acc_q   <= rd_acc_d;
      rd_word_q  <= rd_word_d;
      rdone_q    <= rdone_d;
    end
  end

  assign bus.uart_rdone = rdone_q;
  assign bus.uart_rd    = rd_word_q;

endmodule

`default_nettype wire

// File: doc/uart_word_io.md
# uart_word_io

Word-level UART responder that services the execution unit's `uart_wenable`/`uart_wdone`/`uart_wd` and `uart_renable`/`uart_rdone`/`uart_rd` handshakes. A write request serializes one 32-bit word as four 8N1 bytes on `txd`. A read request returns one 32-bit word assembled from four bytes received on `rxd`. Sits between the core's exec stage and the board's serial pins. Received bytes are buffered, so bytes arriving before a read request are not lost.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per serial bit (100 MHz, 115200 baud); ≥ 4.
- `FIFO_DEPTH`, default 16: RX byte buffer depth; power of two.
- `clk`  in  1: single clock.
- `rstn`  in  1: reset, asynchronous assert, active-low.
- `uart_wenable`  in  1: write request; level-held until `uart_wdone`.
- `uart_wd`  in  32: word to send; sampled on the accepting cycle.
- `uart_wdone`  out  1: one-cycle pulse; the word has fully left `txd`, including the stop bit of byte 4.
- `uart_renable`  in  1: read request; level-held until `uart_rdone`.
- `uart_rdone`  out  1: one-cycle pulse; `uart_rd` is valid.
- `uart_rd`  out  32: received word; holds until the next read completes.
- `txd`  out  1: serial out; idle high.
- `rxd`  in  1: serial in; asynchronous to `clk`.
- `rx_overflow`  out  1: sticky; a byte was dropped because the FIFO was full.

## Operation
- Write and read channels are independent and run concurrently.
- Byte order on the wire: `[31:24]` first, `[7:0]` last.
- Bit order within each byte: LSB first. Frame: 1 start bit (0), 8 data bits, 1 stop bit (1).
- TX FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: when `uart_wenable`=1, latch `uart_wd` and set byte index to 0.
  - START, DATA and STOP each last `CLK_PER_BIT` cycles per bit.
  - After STOP of bytes 0–2, go back to START. After STOP of byte 3, go to DONE.
  - DONE: drive `uart_wdone`=1 for one cycle, then go to IDLE.
  - If `uart_wenable` is still high in the cycle after DONE, it is a new request.
- RX path:
  - `rxd` passes through a 2-flop synchronizer.
  - Start is detected on a 1→0 transition while idle.
  - Start bit is re-checked at `CLK_PER_BIT/2`; if it reads 1, the event is a glitch and RX returns to idle.
  - Data bits are sampled at bit centers.
  - If the stop bit samples 0, the frame is discarded and not pushed.
  - A good byte is pushed into the FIFO. If the FIFO is full, the byte is dropped and `rx_overflow` is set.
- Read FSM states: IDLE, COLLECT, DONE.
  - IDLE: go to COLLECT when `uart_renable`=1.
  - COLLECT: pop one byte per cycle whenever the FIFO is non-empty, shifting in MSB-first. After the 4th pop, go to DONE.
  - DONE: drive `uart_rdone`=1, update `uart_rd`, go to IDLE.
  - A read with an empty FIFO waits indefinitely; there is no timeout.
- FIFO:
  - Simultaneous push and pop is allowed when non-empty; count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Full means count == `FIFO_DEPTH`.

## Timing
- Reset values: `txd`=1, `uart_wdone`=0, `uart_rdone`=0, `uart_rd`=0, `rx_overflow`=0. FIFO is empty and all FSMs are in IDLE.
- Reset mid-operation: `txd` goes high immediately, which may truncate a frame. Partial words and buffered bytes are discarded.
- Write latency: the acceptance cycle is followed by 40·`CLK_PER_BIT` cycles of line activity, then `uart_wdone` in the next cycle.
- `txd` falls to the start bit in the cycle after acceptance.
- Read latency with ≥4 bytes buffered: `uart_rdone` rises 6 cycles after the first cycle `uart_renable` is high (1 to enter COLLECT, 4 pops, 1 DONE).
- RX latency: a byte becomes poppable 2 cycles after its stop-bit sample (1 cycle to push, 1 cycle for the registered FIFO count).
- `uart_wdone` and `uart_rdone` are never high for more than one consecutive cycle.

## Structure
- The shared package holds:
  - TX FSM enum: TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE.
  - Read FSM enum: RD_IDLE, RD_COLLECT, RD_DONE.
  - `UART_BYTES_PER_WORD` = 4.
- One sub-module: `uart_rx_fifo`, a parameterized synchronous byte FIFO with push, pop, empty, full and count.
- TX serializer, RX deserializer and read FSM stay in `uart_word_io`.

## Test plan
- Reset, then write 0x12345678 with `CLK_PER_BIT`=8 → `txd` carries bytes 0x12, 0x34, 0x56, 0x78 as 8N1, LSB-first. `uart_wdone` pulses once, exactly 321 cycles after acceptance.
- Drive bytes 0xDE, 0xAD, 0xBE, 0xEF on `rxd`, then assert `uart_renable` → `uart_rdone` 6 cycles later with `uart_rd`=0xDEADBEEF.
- Assert `uart_renable` first, then send 4 bytes → `uart_rdone` pulses 2 cycles after the last byte becomes poppable; `uart_rd` holds after `uart_renable` drops.
- Send 17 bytes with no read (`FIFO_DEPTH`=16) → `rx_overflow`=1. Four reads then return the first 16 bytes in order.
- Write 0xA5A5A5A5 concurrently with a read of 4 looped-back bytes → both dones fire and neither channel stalls the other.
- Deassert `rstn` in the middle of byte 2 → `txd`=1 and the FIFO is empty immediately. After release, a fresh write completes normally.
